// File: rtl/video_timing_gen_cfg.sv
// Video timing generator with runtime-programmable timing/polarity; new sets commit only at the frame wrap.
// All outputs registered; hs/vs/ad/nf always decode the (hcount_out, vcount_out) shown in the same cycle.
module video_timing_gen_cfg #(
    parameter int H_BITS   = 12,
    parameter int V_BITS   = 11,
    parameter int FC_BITS  = 6,
    parameter int FC_MAX   = 59,
    parameter int DEF_HA   = 1280,
    parameter int DEF_HFP  = 110,
    parameter int DEF_HS   = 40,
    parameter int DEF_HBP  = 220,
    parameter int DEF_VA   = 720,
    parameter int DEF_VFP  = 5,
    parameter int DEF_VS   = 5,
    parameter int DEF_VBP  = 20,
    parameter bit DEF_HPOL = 1'b1,
    parameter bit DEF_VPOL = 1'b1
) (
    input  logic                  clk_pixel_in,
    input  logic                  rst_in,
    input  logic                  enable_in,
    input  logic                  cfg_valid_in,
    output logic                  cfg_ready_out,
    input  logic [4*H_BITS-1:0]   cfg_h_in,
    input  logic [4*V_BITS-1:0]   cfg_v_in,
    input  logic [1:0]            cfg_pol_in,
    output logic                  cfg_err_out,
    output logic [H_BITS-1:0]     hcount_out,
    output logic [V_BITS-1:0]     vcount_out,
    output logic                  hs_out,
    output logic                  vs_out,
    output logic                  ad_out,
    output logic                  nf_out,
    output logic [FC_BITS-1:0]    fc_out
);
    localparam int HW = H_BITS + 2;
    localparam int VW = V_BITS + 2;
    localparam logic [4*H_BITS-1:0] DEF_H = {H_BITS'(DEF_HA), H_BITS'(DEF_HFP), H_BITS'(DEF_HS), H_BITS'(DEF_HBP)};
    localparam logic [4*V_BITS-1:0] DEF_V = {V_BITS'(DEF_VA), V_BITS'(DEF_VFP), V_BITS'(DEF_VS), V_BITS'(DEF_VBP)};
    localparam logic [HW-1:0] H_LIM = HW'(1) << H_BITS;
    localparam logic [VW-1:0] V_LIM = VW'(1) << V_BITS;

    function automatic logic [HW-1:0] h_total(input logic [4*H_BITS-1:0] t);
        return HW'(t[4*H_BITS-1 -: H_BITS]) + HW'(t[3*H_BITS-1 -: H_BITS])
             + HW'(t[2*H_BITS-1 -: H_BITS]) + HW'(t[H_BITS-1:0]);
    endfunction

    function automatic logic [VW-1:0] v_total(input logic [4*V_BITS-1:0] t);
        return VW'(t[4*V_BITS-1 -: V_BITS]) + VW'(t[3*V_BITS-1 -: V_BITS])
             + VW'(t[2*V_BITS-1 -: V_BITS]) + VW'(t[V_BITS-1:0]);
    endfunction

    logic [4*H_BITS-1:0] act_h_q, act_h_d, sh_h_q, sh_h_d;
    logic [4*V_BITS-1:0] act_v_q, act_v_d, sh_v_q, sh_v_d;
    logic [1:0]          act_pol_q, act_pol_d, sh_pol_q, sh_pol_d;
    logic                pend_q, pend_d, started_q, started_d, err_q, err_d;
    logic [H_BITS-1:0]   hcount_q, hcount_d, h_nx;
    logic [V_BITS-1:0]   vcount_q, vcount_d, v_nx;
    logic                hs_q, hs_d, vs_q, vs_d, ad_q, ad_d, nf_q, nf_d;
    logic [FC_BITS-1:0]  fc_q, fc_d;

    logic [HW-1:0] a_ht, c_ht, hs_start, hs_stop;
    logic [VW-1:0] a_vt, c_vt, vs_start, vs_stop;
    logic          h_last, v_last, cfg_bad;
    logic [H_BITS-1:0] n_ha;
    logic [V_BITS-1:0] n_va;

    assign a_ht   = h_total(act_h_q);
    assign a_vt   = v_total(act_v_q);
    assign c_ht   = h_total(cfg_h_in);
    assign c_vt   = v_total(cfg_v_in);
    assign h_last = HW'(hcount_q) == a_ht - HW'(1);
    assign v_last = VW'(vcount_q) == a_vt - VW'(1);

    assign cfg_bad = (cfg_h_in[4*H_BITS-1 -: H_BITS] == '0) || (cfg_h_in[2*H_BITS-1 -: H_BITS] == '0)
                  || (cfg_v_in[4*V_BITS-1 -: V_BITS] == '0) || (cfg_v_in[2*V_BITS-1 -: V_BITS] == '0)
                  || (c_ht > H_LIM) || (c_vt > V_LIM) || (c_ht < HW'(2)) || (c_vt < VW'(2));

    // Decode targets the timing in force at the next position, so a committed set applies from (0,0).
    assign n_ha     = act_h_d[4*H_BITS-1 -: H_BITS];
    assign n_va     = act_v_d[4*V_BITS-1 -: V_BITS];
    assign hs_start = HW'(n_ha) + HW'(act_h_d[3*H_BITS-1 -: H_BITS]);
    assign hs_stop  = hs_start + HW'(act_h_d[2*H_BITS-1 -: H_BITS]);
    assign vs_start = VW'(n_va) + VW'(act_v_d[3*V_BITS-1 -: V_BITS]);
    assign vs_stop  = vs_start + VW'(act_v_d[2*V_BITS-1 -: V_BITS]);

    always_comb begin
        act_h_d   = act_h_q;
        act_v_d   = act_v_q;
        act_pol_d = act_pol_q;
        sh_h_d    = sh_h_q;
        sh_v_d    = sh_v_q;
        sh_pol_d  = sh_pol_q;
        pend_d    = pend_q;
        started_d = started_q;
        err_d     = 1'b0;
        h_nx      = hcount_q;
        v_nx      = vcount_q;
        if (cfg_valid_in && !pend_q) begin
            if (cfg_bad) begin
                err_d = 1'b1;
            end else begin
                sh_h_d   = cfg_h_in;
                sh_v_d   = cfg_v_in;
                sh_pol_d = cfg_pol_in;
                pend_d   = 1'b1;
            end
        end
        if (enable_in) begin
            started_d = 1'b1;
            if (!started_q) begin
                h_nx = '0;
                v_nx = '0;
            end else begin
                if (h_last) begin
                    h_nx = '0;
                    v_nx = v_last ? '0 : vcount_q + V_BITS'(1);
                end else begin
                    h_nx = hcount_q + H_BITS'(1);
                end
                if (h_last && v_last && pend_q) begin
                    act_h_d   = sh_h_q;
                    act_v_d   = sh_v_q;
                    act_pol_d = sh_pol_q;
                    pend_d    = 1'b0;
                end
            end
        end
    end

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        ad_d     = ad_q;
        nf_d     = nf_q;
        fc_d     = fc_q;
        if (enable_in) begin
            hcount_d = h_nx;
            vcount_d = v_nx;
            hs_d     = ((HW'(h_nx) >= hs_start) && (HW'(h_nx) < hs_stop)) ~^ act_pol_d[1];
            vs_d     = ((VW'(v_nx) >= vs_start) && (VW'(v_nx) < vs_stop)) ~^ act_pol_d[0];
            ad_d     = (h_nx < n_ha) && (v_nx < n_va);
            nf_d     = (h_nx == n_ha) && (v_nx == n_va);
            if (nf_d) begin
                fc_d = (fc_q == FC_BITS'(FC_MAX)) ? '0 : fc_q + FC_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            act_h_q   <= DEF_H;
            act_v_q   <= DEF_V;
            act_pol_q <= {DEF_HPOL, DEF_VPOL};
            sh_h_q    <= '0;
            sh_v_q    <= '0;
            sh_pol_q  <= '0;
            pend_q    <= 1'b0;
            started_q <= 1'b0;
            err_q     <= 1'b0;
            hcount_q  <= '0;
            vcount_q  <= '0;
            hs_q      <= ~DEF_HPOL;
            vs_q      <= ~DEF_VPOL;
            ad_q      <= 1'b0;
            nf_q      <= 1'b0;
            fc_q      <= '0;
        end else begin
            act_h_q   <= act_h_d;
            act_v_q   <= act_v_d;
            act_pol_q <= act_pol_d;
            sh_h_q    <= sh_h_d;
            sh_v_q    <= sh_v_d;
            sh_pol_q  <= sh_pol_d;
            pend_q    <= pend_d;
            started_q <= started_d;
            err_q     <= err_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            ad_q      <= ad_d;
            nf_q      <= nf_d;
            fc_q      <= fc_d;
        end
    end

    assign cfg_ready_out = ~pend_q;
    assign cfg_err_out   = err_q;
    assign hcount_out    = hcount_q;
    assign vcount_out    = vcount_q;
    assign hs_out        = hs_q;
    assign vs_out        = vs_q;
    assign ad_out        = ad_q;
    assign nf_out        = nf_q;
    assign fc_out        = fc_q;
endmodule

// File: tb/tb_video_timing_gen_cfg.sv
// Randomised bench for video_timing_gen_cfg against a frame-phase reference model.
// Vertical defaults are shortened so whole default frames fit in a short run; horizontal defaults are kept.
module tb_video_timing_gen_cfg;
    localparam int DVA = 6, DVFP = 2, DVS = 2, DVBP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_in = 1'b0;
    logic        cfg_valid_in = 1'b0;
    logic        cfg_ready_out, cfg_err_out;
    logic [47:0] cfg_h_in = '0;
    logic [43:0] cfg_v_in = '0;
    logic [1:0]  cfg_pol_in = '0;
    logic [11:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hs_out, vs_out, ad_out, nf_out;
    logic [5:0]  fc_out;

    video_timing_gen_cfg #(
        .DEF_VA(DVA), .DEF_VFP(DVFP), .DEF_VS(DVS), .DEF_VBP(DVBP)
    ) dut (
        .clk_pixel_in(clk), .rst_in(rst), .enable_in(enable_in),
        .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out),
        .cfg_h_in(cfg_h_in), .cfg_v_in(cfg_v_in), .cfg_pol_in(cfg_pol_in),
        .cfg_err_out(cfg_err_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hs_out(hs_out), .vs_out(vs_out), .ad_out(ad_out), .nf_out(nf_out), .fc_out(fc_out)
    );

    always #5 clk = ~clk;

    // Model: timing as {HA,HFP,HS,HBP,VA,VFP,VS,VBP}; position is a phase index within the frame.
    int t_act[8], t_sh[8], c[8];
    int p_act[2], p_sh[2], cp[2];
    int m_t, m_fc;
    bit m_started, m_pend, m_err, m_nf;
    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        t_act = '{1280, 110, 40, 220, DVA, DVFP, DVS, DVBP};
        p_act = '{1, 1};
        m_t = 0; m_fc = 0;
        m_started = 0; m_pend = 0; m_err = 0; m_nf = 0;
    endtask

    task automatic model_edge(input bit e, input bit v);
        int ht, vt, cht, cvt;
        bit bad, old_pend, frame_end;
        ht  = t_act[0] + t_act[1] + t_act[2] + t_act[3];
        vt  = t_act[4] + t_act[5] + t_act[6] + t_act[7];
        cht = c[0] + c[1] + c[2] + c[3];
        cvt = c[4] + c[5] + c[6] + c[7];
        bad = (c[0] == 0) || (c[2] == 0) || (c[4] == 0) || (c[6] == 0)
           || (cht > 4096) || (cvt > 2048) || (cht < 2) || (cvt < 2);
        old_pend = m_pend;
        m_err = v && !old_pend && bad;
        if (e) begin
            if (!m_started) begin
                m_started = 1;
                m_t = 0;
            end else begin
                frame_end = (m_t == ht * vt - 1);
                m_t = (m_t + 1) % (ht * vt);
                if (frame_end && old_pend) begin
                    t_act = t_sh; p_act = p_sh; m_pend = 0;
                end
            end
            ht = t_act[0] + t_act[1] + t_act[2] + t_act[3];
            m_nf = (m_t == t_act[4] * ht + t_act[0]);
            if (m_nf) m_fc = (m_fc + 1) % 60;
        end
        if (v && !old_pend && !bad) begin
            t_sh = c; p_sh = cp; m_pend = 1;
        end
    endtask

    task automatic compare_all();
        int ht, x, y;
        bit hr, vr;
        ht = t_act[0] + t_act[1] + t_act[2] + t_act[3];
        x  = m_t % ht;
        y  = m_t / ht;
        hr = (x >= t_act[0] + t_act[1]) && (x < t_act[0] + t_act[1] + t_act[2]);
        vr = (y >= t_act[4] + t_act[5]) && (y < t_act[4] + t_act[5] + t_act[6]);
        check("hcount", hcount_out, x);
        check("vcount", vcount_out, y);
        check("hs", hs_out, (hr == p_act[0]));
        check("vs", vs_out, (vr == p_act[1]));
        check("ad", ad_out, m_started && (x < t_act[0]) && (y < t_act[4]));
        check("nf", nf_out, m_nf);
        check("fc", fc_out, m_fc);
        check("ready", cfg_ready_out, !m_pend);
        check("err", cfg_err_out, m_err);
    endtask

    task automatic step(input bit e, input bit v);
        enable_in    = e;
        cfg_valid_in = v;
        cfg_h_in     = {12'(c[0]), 12'(c[1]), 12'(c[2]), 12'(c[3])};
        cfg_v_in     = {11'(c[4]), 11'(c[5]), 11'(c[6]), 11'(c[7])};
        cfg_pol_in   = {1'(cp[0]), 1'(cp[1])};
        @(posedge clk);
        model_edge(e, v);
        @(negedge clk);
        compare_all();
        cfg_valid_in = 1'b0;
    endtask

    task automatic set_small();
        c  = '{4, 1, 2, 1, 3, 1, 1, 1};
        cp = '{0, 0};
    endtask

    initial begin
        int hs_rise, hs_fall, hmax, vs_first, vmax, nf_x, nf_y, fc_first;
        int nf_cnt, fc_wraps, nf_multi, stall_nf;
        bit prev_hs, prev_nf, found;
        logic [5:0] prev_fc;

        c = '{0, 0, 0, 0, 0, 0, 0, 0};
        cp = '{0, 0};
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Default timing frame, with a small mode offered early that must wait for the wrap.
        hs_rise = -1; hs_fall = -1; hmax = 0; vs_first = -1; vmax = 0;
        nf_x = -1; nf_y = -1; fc_first = -1; prev_hs = 0;
        step(1, 0);
        check("first_ad", ad_out, 1);
        for (int i = 0; i < 19850; i++) begin
            if (i == 100) set_small();
            step(1, i == 100);
            if (i == 100) check("ready_pending", cfg_ready_out, 0);
            if (hs_out && !prev_hs && hs_rise < 0) hs_rise = hcount_out;
            if (!hs_out && prev_hs && hs_fall < 0) hs_fall = hcount_out;
            prev_hs = hs_out;
            if (hcount_out > hmax) hmax = hcount_out;
            if (vcount_out > vmax) vmax = vcount_out;
            if (vs_out && vs_first < 0) vs_first = vcount_out;
            if (nf_out && nf_x < 0) begin
                nf_x = hcount_out; nf_y = vcount_out; fc_first = fc_out;
            end
        end
        check("hs_rise", hs_rise, 1390);
        check("hs_fall", hs_fall, 1430);
        check("hmax", hmax, 1649);
        check("vmax", vmax, DVA + DVFP + DVS + DVBP - 1);
        check("vs_first", vs_first, DVA + DVFP);
        check("nf_x", nf_x, 1280);
        check("nf_y", nf_y, DVA);
        check("fc_first", fc_first, 1);
        check("small_ready", cfg_ready_out, 1);

        // Sixty small frames: fc wraps once, nf never lasts two cycles.
        nf_cnt = 0; fc_wraps = 0; nf_multi = 0; prev_nf = nf_out; prev_fc = fc_out;
        for (int i = 0; i < 60 * 48; i++) begin
            step(1, 0);
            if (nf_out && !prev_nf) nf_cnt++;
            if (nf_out && prev_nf) nf_multi++;
            if (fc_out == 0 && prev_fc == 59) fc_wraps++;
            prev_nf = nf_out; prev_fc = fc_out;
        end
        check("nf_count", nf_cnt, 60);
        check("nf_multi", nf_multi, 0);
        check("fc_wraps", fc_wraps, 1);

        // Rejected sets: HS of zero, then HT one past the counter range.
        c = '{4, 1, 0, 1, 3, 1, 1, 1}; cp = '{1, 1};
        step(1, 1);
        check("rej_hs0_err", cfg_err_out, 1);
        check("rej_hs0_ready", cfg_ready_out, 1);
        step(1, 0);
        check("rej_hs0_clear", cfg_err_out, 0);
        c = '{4000, 50, 40, 7, 3, 1, 1, 1};
        step(1, 1);
        check("rej_ht_err", cfg_err_out, 1);
        check("rej_ht_ready", cfg_ready_out, 1);
        for (int i = 0; i < 50; i++) step(1, 0);

        // Enable stall at h=5.
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1, 0);
            if (hcount_out == 5) found = 1;
        end
        check("stall_wait", found, 1);
        stall_nf = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0);
            if (nf_out) stall_nf++;
        end
        check("stall_h", hcount_out, 5);
        step(1, 0);
        check("resume_h", hcount_out, 6);
        check("stall_nf", stall_nf, 0);

        // Random configs (some invalid) and random enable gaps.
        for (int i = 0; i < 4000; i++) begin
            bit v;
            v = ($urandom_range(0, 15) == 0);
            if (v) begin
                c[0] = $urandom_range(1, 6); c[1] = $urandom_range(0, 3);
                c[2] = $urandom_range(1, 3); c[3] = $urandom_range(0, 3);
                c[4] = $urandom_range(1, 6); c[5] = $urandom_range(0, 3);
                c[6] = $urandom_range(1, 3); c[7] = $urandom_range(0, 3);
                if ($urandom_range(0, 7) == 0) c[$urandom_range(0, 7)] = 0;
                cp[0] = $urandom_range(0, 1); cp[1] = $urandom_range(0, 1);
            end
            step($urandom_range(0, 9) != 0, v);
        end

        // Async reset while a set is pending.
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(1, 0);
            if (cfg_ready_out) found = 1;
        end
        check("pre_rst_ready", found, 1);
        set_small();
        step(1, 1);
        check("pre_rst_pending", cfg_ready_out, 0);
        for (int i = 0; i < 5; i++) step(1, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("arst_ready", cfg_ready_out, 1);
        check("arst_ad", ad_out, 0);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        hs_rise = -1; prev_hs = 0;
        for (int i = 0; i < 19850; i++) begin
            step(1, 0);
            if (hs_out && !prev_hs && hs_rise < 0) hs_rise = hcount_out;
            prev_hs = hs_out;
        end
        check("post_rst_hs_rise", hs_rise, 1390);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/video_timing_gen_cfg.md
Name: video_timing_gen_cfg

Overview:
- Next-generation video timing generator with runtime-programmable timing and sync polarity.
- Generates pixel/line counters, hsync/vsync, active-display, new-frame pulse and frame counter.
- New timing sets are accepted through a valid/ready handshake and applied only at a frame boundary, so a frame is never torn.
- Sits between the pixel clock domain source and the TMDS/HDMI encoder. Drives all downstream pixel pipelines.

Parameters:
- H_BITS, 12: width of hcount_out and of all horizontal timing fields.
- V_BITS, 11: width of vcount_out and of all vertical timing fields.
- FC_BITS, 6: width of fc_out.
- FC_MAX, 59: fc_out wraps to 0 after this value.
- DEF_HA/DEF_HFP/DEF_HS/DEF_HBP, 1280/110/40/220: horizontal timing loaded at reset.
- DEF_VA/DEF_VFP/DEF_VS/DEF_VBP, 720/5/5/20: vertical timing loaded at reset.
- DEF_HPOL, 1: hsync polarity at reset (1 = active-high).
- DEF_VPOL, 1: vsync polarity at reset (1 = active-high).

Ports:
- clk_pixel_in  in  1  pixel clock
- rst_in  in  1  asynchronous active-high reset
- enable_in  in  1  1 = advance timing; 0 = freeze all state
- cfg_valid_in  in  1  new timing set offered
- cfg_ready_out  out  1  1 = no pending config; may accept
- cfg_h_in  in  4*H_BITS  {HA,HFP,HS,HBP}, HA in MSBs
- cfg_v_in  in  4*V_BITS  {VA,VFP,VS,VBP}, VA in MSBs
- cfg_pol_in  in  2  {hpol,vpol}
- cfg_err_out  out  1  one-cycle pulse: offered config rejected
- hcount_out  out  H_BITS  current pixel x
- vcount_out  out  V_BITS  current line y
- hs_out  out  1  hsync, polarity applied
- vs_out  out  1  vsync, polarity applied
- ad_out  out  1  active display
- nf_out  out  1  new-frame pulse
- fc_out  out  FC_BITS  frame counter

Behaviour:
- Reset (async assert):
  - hcount=0, vcount=0, ad=0, nf=0, fc=0, cfg_ready=1, cfg_err=0.
  - hs/vs at inactive level per DEF_HPOL/DEF_VPOL.
  - Active timing registers are loaded with the DEF_* parameters.
- All outputs are registered and mutually consistent: the hs/vs/ad/nf values in any cycle describe the position (hcount_out, vcount_out) shown in that same cycle.
- First enabled edge after reset deassert presents position (0,0) with ad_out=1.
- Totals: HT=HA+HFP+HS+HBP, VT=VA+VFP+VS+VBP, computed in H_BITS+2 / V_BITS+2 bits.
- Counters: hcount increments, wrapping at HT-1 to 0. vcount increments when hcount wraps, and wraps at VT-1 to 0.
- Raw decode:
  - hs_raw = HA+HFP <= h < HA+HFP+HS
  - vs_raw = VA+VFP <= v < VA+VFP+VS, held for whole lines
  - ad = h<HA && v<VA
- Sync outputs: hs_out = hs_raw XNOR hpol; vs_out = vs_raw XNOR vpol.
- New frame: nf_out=1 for exactly one cycle at position (HA, VA). In that same cycle fc_out shows the incremented value, wrapping FC_MAX to 0.
- enable_in=0: counters, all outputs, fc and pending config hold. nf_out is not re-pulsed on resume.
- Config handshake:
  - Transfer occurs on cfg_valid_in && cfg_ready_out.
  - The set is checked in the transfer cycle and rejected (cfg_err_out=1 next cycle, nothing stored, cfg_ready stays 1) if any of these hold:
    - HA==0, HS==0, VA==0 or VS==0
    - HT > 2^H_BITS or VT > 2^V_BITS
    - HT < 2 or VT < 2
  - An accepted set is stored in shadow registers and cfg_ready_out drops to 0 next cycle.
  - The shadow is committed on the cycle the counters wrap from (HT-1, VT-1) to (0,0), with enable high. The position (0,0) is decoded with the new timing and polarity.
  - cfg_ready_out returns to 1 on the cycle after commit.
- Simultaneous transfer and wrap: the new set waits for the next frame wrap. It is not committed in the same cycle.
- Reset mid-pending: the shadow is discarded and DEF_* timing is restored.
- Counters never exceed HT-1/VT-1 under any committed timing.

Test Plan:
1. Reset defaults: release rst, enable=1. Expect hs rises at h=1390, falls at h=1430; line wrap after h=1649; vs asserted for v=725..729; nf at (1280,720); fc=1 after the first frame; vcount wraps at 749.
2. Small mode: offer HA=4,HFP=1,HS=2,HBP=1, VA=3,VFP=1,VS=1,VBP=1, pol=2'b00. Expect cfg_ready=0 until the default frame wraps. Then 48-cycle frames: hs_out=0 at h=5,6; vs_out=0 on v=4; ad for h<4,v<3; nf at (4,3).
3. fc wrap: run 60 small-mode frames from fc=0. Expect fc 59 -> 0 at the 60th nf, with nf a single-cycle pulse each frame.
4. Rejection: offer HS=0. Expect cfg_err_out pulse one cycle later, cfg_ready stays 1, timing unchanged. Offer HT=4097 with H_BITS=12: same response.
5. Enable stall: drop enable for 10 cycles at h=5. Expect all outputs frozen for those cycles, resuming at h=6 with no extra nf.
6. Async reset with a config pending mid-frame. Expect outputs at reset values immediately without a clock edge, cfg_ready=1, and DEF timing after release.
